// File: rtl/ps2_dev_rxtx_if.sv
// Purpose : user-side bundle of the PS/2 device endpoint (tx request, status ticks, rx byte).
// Latency : n/a (signal bundle only).
// Backpr. : none; wr_dev is dropped unless the endpoint is idle with no host request-to-send.
// Ports   : wr_dev/din (master -> device); tx_busy, tx_done_tick, tx_abort_tick,
//           rx_done_tick, rx_err_tick, dout (device -> master).
interface ps2_dev_rxtx_if;
  logic       wr_dev;
  logic [7:0] din;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx_abort_tick;
  logic       rx_done_tick;
  logic       rx_err_tick;
  logic [7:0] dout;

  modport master (
    output wr_dev, din,
    input  tx_busy, tx_done_tick, tx_abort_tick, rx_done_tick, rx_err_tick, dout
  );

  modport slave (
    input  wr_dev, din,
    output tx_busy, tx_done_tick, tx_abort_tick, rx_done_tick, rx_err_tick, dout
  );
endinterface

// File: rtl/ps2_dev_rxtx.sv
// Purpose : device side of a PS/2 link; generates ps2c, sends bytes to the host, receives
//           host commands (request-to-send, 10 data/parity/stop pulses, ack pulse).
// Latency : tx starts after IDLE_HOLD cycles of idle clock, then 11 bits of 2*HALF_PER cycles;
//           rx result ticks at the end of the 11th clock pulse (or at the stop sample on error).
// Backpr. : wr_dev is accepted only in idle with no host RTS; otherwise it is dropped.
// Ports   : clk, rst (sync, active-high); bus (slave modport of ps2_dev_rxtx_if);
//           ps2c, ps2d open-drain lines, driven 0 or Z only.
module ps2_dev_rxtx #(
  parameter int HALF_PER  = 2500,
  parameter int IDLE_HOLD = 2500
) (
  input  logic          clk,
  input  logic          rst,
  ps2_dev_rxtx_if.slave bus,
  inout  wire           ps2c,
  inout  wire           ps2d
);

  localparam int MAXC = (HALF_PER > IDLE_HOLD) ? HALF_PER : IDLE_HOLD;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_PER - 1);
  localparam logic [CW-1:0] C_QTR  = CW'(HALF_PER / 2 - 1);
  localparam logic [CW-1:0] C_HOLD = CW'(IDLE_HOLD - 1);

  // TX bit: PH_A data setup (clock high), PH_L clock low, PH_B clock high.
  // RX pulse uses PH_L (low) and PH_B (high) only.
  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_L = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_HOLD, S_TX_BIT, S_RX_START, S_RX_BIT, S_RX_WAIT
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [3:0]    r_idx, w_idx;
  logic [1:0]    r_ph, w_ph;
  logic [10:0]   r_frame, w_frame;   // tx frame, LSB is the bit on the wire
  logic [9:0]    r_sh, w_sh;         // rx shift: d0..d7, parity, stop (first in ends at [0])
  logic          r_ack, w_ack;
  logic          r_busy, w_busy;
  logic [7:0]    r_dout, w_dout;
  logic          r_tx_done, w_tx_done, r_tx_abort, w_tx_abort;
  logic          r_rx_done, w_rx_done, r_rx_err, w_rx_err;
  logic          r_c_meta, r_sc, r_d_meta, r_sd;
  logic          w_c_low, w_d_low;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_meta   <= 1'b1;
      r_sc       <= 1'b1;
      r_d_meta   <= 1'b1;
      r_sd       <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ph       <= PH_A;
      r_frame    <= '1;
      r_sh       <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_dout     <= 8'h00;
      r_tx_done  <= 1'b0;
      r_tx_abort <= 1'b0;
      r_rx_done  <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_c_meta   <= ps2c;
      r_sc       <= r_c_meta;
      r_d_meta   <= ps2d;
      r_sd       <= r_d_meta;
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_ph       <= w_ph;
      r_frame    <= w_frame;
      r_sh       <= w_sh;
      r_ack      <= w_ack;
      r_busy     <= w_busy;
      r_dout     <= w_dout;
      r_tx_done  <= w_tx_done;
      r_tx_abort <= w_tx_abort;
      r_rx_done  <= w_rx_done;
      r_rx_err   <= w_rx_err;
    end
  end

  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state and datapath update.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_ph       = r_ph;
    w_frame    = r_frame;
    w_sh       = r_sh;
    w_ack      = r_ack;
    w_busy     = r_busy;
    w_dout     = r_dout;
    w_tx_done  = 1'b0;
    w_tx_abort = 1'b0;
    w_rx_done  = 1'b0;
    w_rx_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (r_sc && !r_sd) begin
          w_state = S_RX_START;          // host RTS wins over a same-cycle wr_dev
        end else if (bus.wr_dev) begin
          w_frame = {1'b1, ~^bus.din, bus.din, 1'b0};
          w_busy  = 1'b1;
          w_state = S_TX_HOLD;
        end
      end

      S_TX_HOLD: begin
        if (!r_sc) begin
          w_cnt = '0;
        end else if (r_cnt == C_HOLD) begin
          w_state = S_TX_BIT;
          w_idx   = 4'd0;
          w_ph    = PH_A;
          w_cnt   = '0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end

      S_TX_BIT: begin
        w_cnt = w_cnt_inc;
        case (r_ph)
          PH_A: if (r_cnt == C_QTR) begin
            w_cnt = '0;
            // Last cycle of the clock-high phase: a low clock here is the host inhibiting.
            if (!r_sc && r_idx < 4'd10) begin
              w_state    = S_IDLE;
              w_busy     = 1'b0;
              w_tx_abort = 1'b1;
            end else begin
              w_ph = PH_L;
            end
          end
          PH_L: if (r_cnt == C_HALF) begin
            w_cnt = '0;
            w_ph  = PH_B;
          end
          default: if (r_cnt == C_QTR) begin
            w_cnt = '0;
            if (r_idx == 4'd10) begin
              w_state   = S_IDLE;
              w_busy    = 1'b0;
              w_tx_done = 1'b1;
            end else begin
              w_idx   = r_idx + 4'd1;
              w_frame = {1'b0, r_frame[10:1]};
              w_ph    = PH_A;
            end
          end
        endcase
      end

      S_RX_START: begin
        if (r_cnt == C_QTR) begin
          w_state = S_RX_BIT;
          w_idx   = 4'd1;
          w_ph    = PH_L;
          w_cnt   = '0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end

      S_RX_BIT: begin
        w_cnt = w_cnt_inc;
        if (r_ph == PH_L) begin
          if (r_cnt == C_HALF) begin
            w_cnt = '0;
            w_ph  = PH_B;
          end
        end else if (r_cnt == C_QTR && r_idx <= 4'd10) begin
          // Mid-high sample; pulse 10 carries the stop bit and decides on the ack.
          w_sh = {r_sd, r_sh[9:1]};
          if (r_idx == 4'd10) begin
            if (!r_sd) begin
              w_dout   = r_sh[8:1];
              w_rx_err = 1'b1;
              w_state  = S_RX_WAIT;
              w_cnt    = '0;
            end else begin
              w_ack = 1'b1;
            end
          end
        end else if (r_cnt == C_HALF) begin
          w_cnt = '0;
          if (!r_sc) begin
            w_state = S_IDLE;            // host inhibit: drop the command silently
            w_ack   = 1'b0;
          end else if (r_idx == 4'd11) begin
            w_ack  = 1'b0;
            w_dout = r_sh[7:0];
            if (^r_sh[8:0]) w_rx_done = 1'b1;
            else            w_rx_err  = 1'b1;
            // Wait for the released ack to propagate through the synchronizer,
            // otherwise idle would mistake it for a new RTS.
            w_state = S_RX_WAIT;
          end else begin
            w_idx = r_idx + 4'd1;
            w_ph  = PH_L;
          end
        end
      end

      S_RX_WAIT: begin
        if (r_sd) w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase
  end

  // Line drives decoded from registered state; idle and reset release both lines.
  always_comb begin
    w_c_low = 1'b0;
    w_d_low = 1'b0;
    if (r_state == S_TX_BIT) begin
      w_c_low = (r_ph == PH_L);
      w_d_low = ~r_frame[0];
    end else if (r_state == S_RX_BIT) begin
      w_c_low = (r_ph == PH_L);
      w_d_low = r_ack;
    end
  end

  assign ps2c = w_c_low ? 1'b0 : 1'bz;
  assign ps2d = w_d_low ? 1'b0 : 1'bz;

  assign bus.tx_busy       = r_busy;
  assign bus.tx_done_tick  = r_tx_done;
  assign bus.tx_abort_tick = r_tx_abort;
  assign bus.rx_done_tick  = r_rx_done;
  assign bus.rx_err_tick   = r_rx_err;
  assign bus.dout          = r_dout;

endmodule

// File: tb/tb_ps2_dev_rxtx.sv
// Purpose : directed bench for ps2_dev_rxtx with a pulled-up open-drain host model.
// Latency : n/a.
// Backpr. : n/a.
module tb_ps2_dev_rxtx;
  localparam int HP = 8;
  localparam int IH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire  ps2c;
  wire  ps2d;
  logic h_c_low = 1'b0;
  logic h_d_low = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = h_c_low ? 1'b0 : 1'bz;
  assign ps2d = h_d_low ? 1'b0 : 1'bz;

  ps2_dev_rxtx_if bus ();

  ps2_dev_rxtx #(.HALF_PER(HP), .IDLE_HOLD(IH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .ps2c (ps2c),
    .ps2d (ps2d)
  );

  int checks   = 0;
  int failures = 0;

  // Passive monitors (written only here).
  int   cyc    = 0;
  int   n_txd  = 0;
  int   n_txa  = 0;
  int   n_rxd  = 0;
  int   n_rxe  = 0;
  int   n_busy = 0;
  int   n_ovl  = 0;
  int   fall_t[$];
  logic fall_d[$];
  logic prev_c = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_done_tick  === 1'b1) n_txd++;
    if (bus.tx_abort_tick === 1'b1) n_txa++;
    if (bus.rx_done_tick  === 1'b1) n_rxd++;
    if (bus.rx_err_tick   === 1'b1) n_rxe++;
    if (bus.tx_busy       === 1'b1) n_busy++;
    if ($countones({bus.tx_done_tick, bus.tx_abort_tick, bus.rx_done_tick, bus.rx_err_tick}) > 1)
      n_ovl++;
    if (prev_c === 1'b1 && ps2c === 1'b0) begin
      fall_t.push_back(cyc);
      fall_d.push_back(ps2d);
    end
    prev_c = ps2c;
  end

  task automatic wait_fall(input int limit, output bit ok);
    logic p;
    p  = ps2c;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (p === 1'b1 && ps2c === 1'b0) begin
        ok = 1'b1;
        break;
      end
      p = ps2c;
    end
  endtask

  // Host command: RTS, then 10 bits shifted on device falling edges, then observe pulse 11.
  task automatic host_rx(input logic [7:0] data, input logic par, input logic stop,
                         input bit with_wr, output bit all_edges, output bit pulse11,
                         output logic ack_d);
    logic [9:0] bits;
    bit ok;
    bits      = {stop, par, data};
    all_edges = 1'b1;
    h_c_low = 1'b1;
    repeat (100) @(negedge clk);
    h_d_low = 1'b1;
    repeat (5) @(negedge clk);
    h_c_low = 1'b0;
    if (with_wr) begin
      // Aligned so wr_dev is high in the first cycle the synced lines show RTS.
      @(negedge clk);
      @(negedge clk);
      bus.din    = 8'h12;
      bus.wr_dev = 1'b1;
      @(negedge clk);
      bus.wr_dev = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      wait_fall(60, ok);
      if (!ok) all_edges = 1'b0;
      h_d_low = ~bits[i];
    end
    wait_fall(40, ok);
    pulse11 = ok;
    ack_d   = ps2d;
    h_d_low = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    bus.wr_dev = 1'b0;
    bus.din    = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.tx_busy); end
    checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
    checks++; if ({bus.tx_done_tick, bus.tx_abort_tick, bus.rx_done_tick, bus.rx_err_tick} !== 4'b0000) begin
      failures++; $display("FAIL reset_ticks got=%b exp=0000",
        {bus.tx_done_tick, bus.tx_abort_tick, bus.rx_done_tick, bus.rx_err_tick}); end
    checks++; if ({ps2c, ps2d} !== 2'b11) begin failures++; $display("FAIL reset_lines got=%b exp=11", {ps2c, ps2d}); end
    rst = 1'b0;
    @(negedge clk);
    bus.wr_dev = 1'b1;
    bus.din    = 8'hFA;
    @(negedge clk);
    bus.wr_dev = 1'b0;
    wait_fall(100, ok);
    checks++; if (!ok || ps2d !== 1'b0) begin failures++; $display("FAIL midtx_start edge=%0d d=%b exp edge=1 d=0", ok, ps2d); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({ps2c, ps2d} !== 2'b11) begin failures++; $display("FAIL midtx_rst_lines got=%b exp=11", {ps2c, ps2d}); end
    checks++; if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL midtx_rst_busy got=%b exp=0", bus.tx_busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL midtx_rst_dout got=%h exp=00", bus.dout); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_tx(input logic [7:0] b, input logic [10:0] exp_bits);
    int s, td0, ta0, nbad;
    bit done;
    s   = fall_t.size();
    td0 = n_txd;
    ta0 = n_txa;
    bus.wr_dev = 1'b1;
    bus.din    = b;
    @(negedge clk);
    bus.wr_dev = 1'b0;
    checks++; if (bus.tx_busy !== 1'b1) begin failures++; $display("FAIL tx_busy_set byte=%h got=%b exp=1", b, bus.tx_busy); end
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.tx_done_tick === 1'b1) begin done = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    checks++; if (!done) begin failures++; $display("FAIL tx_done_seen byte=%h got=0 exp=1", b); end
    checks++; if (fall_t.size() - s !== 11) begin failures++; $display("FAIL tx_edges byte=%h got=%0d exp=11", b, fall_t.size() - s); end
    for (int k = 0; k < 11; k++) begin
      if (s + k < fall_t.size()) begin
        checks++;
        if (fall_d[s + k] !== exp_bits[k]) begin
          failures++; $display("FAIL tx_bit byte=%h idx=%0d got=%b exp=%b", b, k, fall_d[s + k], exp_bits[k]);
        end
      end
    end
    nbad = 0;
    for (int k = 1; k < 11; k++)
      if (s + k < fall_t.size() && fall_t[s + k] - fall_t[s + k - 1] != 2 * HP) nbad++;
    checks++; if (nbad !== 0) begin failures++; $display("FAIL tx_spacing byte=%h bad_gaps=%0d exp=0", b, nbad); end
    checks++; if (n_txd - td0 !== 1) begin failures++; $display("FAIL tx_done_count byte=%h got=%0d exp=1", b, n_txd - td0); end
    checks++; if (n_txa - ta0 !== 0) begin failures++; $display("FAIL tx_no_abort byte=%h got=%0d exp=0", b, n_txa - ta0); end
    checks++; if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL tx_busy_clr byte=%h got=%b exp=0", b, bus.tx_busy); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_tx_abort();
    int td0, ta0, nok;
    bit ok, got;
    td0 = n_txd;
    ta0 = n_txa;
    nok = 0;
    bus.wr_dev = 1'b1;
    bus.din    = 8'h0F;  // d4=0, so bit 5 drives data low when the abort lands
    @(negedge clk);
    bus.wr_dev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_fall(100, ok);
      if (!ok) nok++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ps2c === 1'b1) break;
    end
    h_c_low = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.tx_abort_tick === 1'b1) begin got = 1'b1; break; end
    end
    repeat (10) @(negedge clk);
    checks++; if (!got || nok != 0) begin failures++; $display("FAIL abort_tick got=%b missing_edges=%0d exp tick=1 missing=0", got, nok); end
    checks++; if (ps2d !== 1'b1) begin failures++; $display("FAIL abort_data_released got=%b exp=1", ps2d); end
    checks++; if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.tx_busy); end
    checks++; if (n_txa - ta0 !== 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", n_txa - ta0); end
    checks++; if (n_txd - td0 !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", n_txd - td0); end
    h_c_low = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (ps2c !== 1'b1) begin failures++; $display("FAIL abort_clk_released got=%b exp=1", ps2c); end
  endtask

  task automatic test_rx_ok();
    int rd0, re0;
    bit all_e, p11;
    logic ack;
    rd0 = n_rxd; re0 = n_rxe;
    host_rx(8'hF4, 1'b0, 1'b1, 1'b0, all_e, p11, ack);
    checks++; if (!all_e || !p11) begin failures++; $display("FAIL rx_ok_pulses edges=%b p11=%b exp 1 1", all_e, p11); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rx_ok_ack got=%b exp=0", ack); end
    checks++; if (bus.dout !== 8'hF4) begin failures++; $display("FAIL rx_ok_dout got=%h exp=f4", bus.dout); end
    checks++; if (n_rxd - rd0 !== 1 || n_rxe - re0 !== 0) begin
      failures++; $display("FAIL rx_ok_ticks done=%0d err=%0d exp 1 0", n_rxd - rd0, n_rxe - re0); end
  endtask

  task automatic test_rx_parity_err();
    int rd0, re0;
    bit all_e, p11;
    logic ack;
    rd0 = n_rxd; re0 = n_rxe;
    host_rx(8'hF4, 1'b1, 1'b1, 1'b0, all_e, p11, ack);
    checks++; if (!all_e || !p11) begin failures++; $display("FAIL rx_par_pulses edges=%b p11=%b exp 1 1", all_e, p11); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rx_par_ack got=%b exp=0", ack); end
    checks++; if (bus.dout !== 8'hF4) begin failures++; $display("FAIL rx_par_dout got=%h exp=f4", bus.dout); end
    checks++; if (n_rxd - rd0 !== 0 || n_rxe - re0 !== 1) begin
      failures++; $display("FAIL rx_par_ticks done=%0d err=%0d exp 0 1", n_rxd - rd0, n_rxe - re0); end
  endtask

  task automatic test_rx_stop_err();
    int rd0, re0;
    bit all_e, p11;
    logic ack;
    rd0 = n_rxd; re0 = n_rxe;
    host_rx(8'h3C, 1'b1, 1'b0, 1'b0, all_e, p11, ack);
    checks++; if (!all_e) begin failures++; $display("FAIL rx_stop_edges got=0 exp=1"); end
    checks++; if (p11 !== 1'b0) begin failures++; $display("FAIL rx_stop_no_pulse11 got=%b exp=0", p11); end
    checks++; if (bus.dout !== 8'h3C) begin failures++; $display("FAIL rx_stop_dout got=%h exp=3c", bus.dout); end
    checks++; if (n_rxd - rd0 !== 0 || n_rxe - re0 !== 1) begin
      failures++; $display("FAIL rx_stop_ticks done=%0d err=%0d exp 0 1", n_rxd - rd0, n_rxe - re0); end
  endtask

  task automatic test_priority();
    int rd0, b0, td0, ta0;
    bit all_e, p11;
    logic ack;
    rd0 = n_rxd; b0 = n_busy; td0 = n_txd; ta0 = n_txa;
    host_rx(8'hA5, 1'b1, 1'b1, 1'b1, all_e, p11, ack);
    checks++; if (!all_e || !p11 || ack !== 1'b0) begin
      failures++; $display("FAIL prio_rx edges=%b p11=%b ack=%b exp 1 1 0", all_e, p11, ack); end
    checks++; if (bus.dout !== 8'hA5 || n_rxd - rd0 !== 1) begin
      failures++; $display("FAIL prio_rx_result dout=%h done=%0d exp a5 1", bus.dout, n_rxd - rd0); end
    checks++; if (n_busy - b0 !== 0) begin failures++; $display("FAIL prio_busy_cycles got=%0d exp=0", n_busy - b0); end
    checks++; if (n_txd - td0 !== 0 || n_txa - ta0 !== 0) begin
      failures++; $display("FAIL prio_tx_ticks done=%0d abort=%0d exp 0 0", n_txd - td0, n_txa - ta0); end
  endtask

  task automatic test_no_overlap();
    checks++; if (n_ovl !== 0) begin failures++; $display("FAIL tick_overlap got=%0d exp=0", n_ovl); end
  endtask

  initial begin
    bus.wr_dev = 1'b0;
    bus.din    = 8'h00;
    test_reset();
    test_tx(8'hFA, 11'b111_1111_0100);
    test_tx_abort();
    test_tx(8'hAA, 11'b111_0101_0100);
    test_rx_ok();
    test_rx_parity_err();
    test_rx_stop_err();
    test_priority();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
